// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB transfer/burst codes and helper functions
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    // Number of bits needed to index n items (n >= 2).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Total beats of a burst; 0 marks the undefined-length INCR.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_SINGLE:                return 5'd1;
            HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            default:                      return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_arb_select.sv
// rtl/ahb_arb_select.sv - combinational next-grant picker (fixed priority or round-robin)
module ahb_arb_select
    import ahb_pkg::*;
#(
    parameter int NUM_MASTER     = 2,
    parameter int MODE           = 0,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic [NUM_MASTER-1:0]        req,
    input  logic [clog2(NUM_MASTER)-1:0] ptr,
    output logic [NUM_MASTER-1:0]        grant,
    output logic [clog2(NUM_MASTER)-1:0] idx,
    output logic                         any_req
);

    localparam int MW = clog2(NUM_MASTER);

    // Scan requesters from index 0 (fixed) or from just after ptr with wrap (round-robin).
    always_comb begin : pick
        int             cand;
        logic [MW-1:0]  cand_i;
        logic           found;
        cand    = 0;
        cand_i  = '0;
        found   = 1'b0;
        any_req = |req;
        idx     = MW'(DEFAULT_MASTER);
        for (int k = 0; k < NUM_MASTER; k++) begin
            if (MODE == 0) begin
                cand = k;
            end else begin
                cand = (int'(ptr) + k + 1) % NUM_MASTER;
            end
            cand_i = MW'(cand);
            if (!found && req[cand_i]) begin
                found = 1'b1;
                idx   = cand_i;
            end
        end
        grant      = '0;
        grant[idx] = 1'b1;
    end

endmodule

// File: rtl/ahb_arbiter_mn.sv
// rtl/ahb_arbiter_mn.sv - N-master AHB arbiter; AHB_ARB_HOLD_LIMIT_EN caps undefined INCR ownership
module ahb_arbiter_mn
    import ahb_pkg::*;
#(
    parameter int NUM_MASTER     = 2,
    parameter int MODE           = 0,
    parameter int DEFAULT_MASTER = 0,
    parameter int HOLD_LIMIT     = 16
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [NUM_MASTER-1:0]        HBUSREQ,
    input  logic [NUM_MASTER-1:0]        HLOCK,
    input  logic [1:0]                   HTRANS,
    input  logic [2:0]                   HBURST,
    input  logic                         HREADY,
    output logic [NUM_MASTER-1:0]        HGRANT,
    output logic [clog2(NUM_MASTER)-1:0] HMASTER,
    output logic [clog2(NUM_MASTER)-1:0] HMASTER_D,
    output logic                         HMASTLOCK
);

    localparam int                    MW        = clog2(NUM_MASTER);
    localparam logic [MW-1:0]         DEF_IDX   = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTER-1:0] DEF_GRANT = NUM_MASTER'(1) << DEFAULT_MASTER;

    logic [NUM_MASTER-1:0] grant_q;
    logic [MW-1:0]         hmaster_q;
    logic [MW-1:0]         hmaster_d_q;
    logic                  hmastlock_q;
    logic [3:0]            beat_cnt;
    logic                  undef_q;
    logic [MW-1:0]         rr_ptr;

    logic [MW-1:0]         grant_idx;
    logic [NUM_MASTER-1:0] sel_grant;
    logic [MW-1:0]         sel_idx;
    logic                  any_req;
    logic                  is_nonseq;
    logic                  is_seq;
    logic                  is_idle;
    logic [4:0]            beats;
    logic [3:0]            load_val;
    logic                  locked_hold;
    logic                  undefined_active;
    logic                  hold_limit_hit;
    logic                  cnt_ok;
    logic                  arb_ok;

    assign is_nonseq = (HTRANS == HTRANS_NONSEQ);
    assign is_seq    = (HTRANS == HTRANS_SEQ);
    assign is_idle   = (HTRANS == HTRANS_IDLE);

    // Counter holds beats remaining after the current one.
    assign beats    = burst_beats(HBURST);
    assign load_val = (beats == 5'd0) ? 4'd0 : 4'(beats - 5'd1);

    // Re-arbitration is allowed on the last beat of a burst, never inside a locked
    // sequence, and never while an undefined INCR owner keeps requesting.
    assign locked_hold      = hmastlock_q || HLOCK[hmaster_q];
    assign undefined_active = undef_q && HBUSREQ[hmaster_q] && !hold_limit_hit;
    assign cnt_ok           = (beat_cnt == 4'd0) ||
                              ((beat_cnt == 4'd1) && is_seq && HREADY);
    assign arb_ok           = !locked_hold && cnt_ok && !undefined_active;

    // One-hot grant register back to an owner index.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MASTER; i++) begin
            if (grant_q[i]) begin
                grant_idx = MW'(i);
            end
        end
    end

    ahb_arb_select #(
        .NUM_MASTER     (NUM_MASTER),
        .MODE           (MODE),
        .DEFAULT_MASTER (DEFAULT_MASTER)
    ) u_select (
        .req     (HBUSREQ),
        .ptr     (rr_ptr),
        .grant   (sel_grant),
        .idx     (sel_idx),
        .any_req (any_req)
    );

    // Grant and round-robin pointer move only at an arbitration point on a ready edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q <= DEF_GRANT;
            rr_ptr  <= DEF_IDX;
        end else if (arb_ok && HREADY) begin
            grant_q <= sel_grant;
            if (any_req && (sel_grant != grant_q)) begin
                rr_ptr <= sel_idx;
            end
        end
    end

    // Address-phase owner follows the grant, data-phase owner follows the address phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hmaster_q   <= DEF_IDX;
            hmaster_d_q <= DEF_IDX;
            hmastlock_q <= 1'b0;
        end else if (HREADY) begin
            hmaster_q   <= grant_idx;
            hmaster_d_q <= hmaster_q;
            hmastlock_q <= HLOCK[grant_idx];
        end
    end

    // Track beats left in the current burst and whether it is an undefined INCR.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            beat_cnt <= 4'd0;
            undef_q  <= 1'b0;
        end else if (HREADY) begin
            if (is_nonseq) begin
                beat_cnt <= load_val;
                undef_q  <= (HBURST == HBURST_INCR);
            end else if (is_seq) begin
                if (beat_cnt != 4'd0) begin
                    beat_cnt <= beat_cnt - 4'd1;
                end
            end else if (is_idle) begin
                undef_q <= 1'b0;
            end
        end
    end

`ifdef AHB_ARB_HOLD_LIMIT_EN
    localparam int HW = clog2(HOLD_LIMIT + 1) + 1;

    logic [HW-1:0] hold_cnt;

    // Count accepted beats since the last NONSEQ, saturating at the limit.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_cnt <= '0;
        end else if (HREADY && is_nonseq) begin
            hold_cnt <= HW'(1);
        end else if (HREADY && is_seq && (hold_cnt < HW'(HOLD_LIMIT))) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    assign hold_limit_hit = (hold_cnt >= HW'(HOLD_LIMIT));
`else
    assign hold_limit_hit = 1'b0;
`endif

    assign HGRANT    = grant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTER_D = hmaster_d_q;
    assign HMASTLOCK = hmastlock_q;

endmodule
